reg_read_arbiter: RTL

Round-robin arbiter and sequencer that shares one 16-entry, 16-bit register read path among four requesters. The read path is the 16:1 word-select mux on the register bank. Each cycle the block picks at most one pending requester and drives the mux select with that requester's register address. One cycle later it captures the mux output and returns it with a one-hot valid tag. It sits between the register bank's read mux and the blocks that read registers, such as decode, debug and DMA ports.

---
 rtl/reg_read_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/reg_read_arbiter.sv
// reg_read_arbiter
// Round-robin arbiter that shares one register-bank read mux among NREQ
// requesters. Stage 1 grants a requester and drives the mux select with its
// address. Stage 2 captures the mux output and tags it with a one-hot valid
// that names the requester it belongs to.
//
// pri | meaning
// ----+--------------------------------------------
//  n  | requester n is scanned first in the next arbitration

module reg_read_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*AW-1:0]   ADDR,
    output logic [NREQ-1:0]      GNT,
    output logic [AW-1:0]        MUX_SEL,
    input  logic [DW-1:0]        MUX_DATA,
    output logic [DW-1:0]        RDATA,
    output logic [NREQ-1:0]      RVALID
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   pri;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   win;
    logic            found;
    logic [NREQ-1:0] win_oh;
    logic [AW-1:0]   win_addr;

    // Scan the requests starting at pri, wrapping around, and pick the first
    // one that is set. NREQ is a power of two, so the index wraps on its own.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        win_oh   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = pri + PW'(k);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            win_oh[win] = 1'b1;
        end
        win_addr = ADDR[win*AW +: AW];
    end

    // Grant stage: issue the grant pulse, steer the read mux, and rotate the
    // priority to just past the winner. Idle cycles leave the select and the
    // pointer alone, so the mux is not switched without a grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT     <= '0;
            MUX_SEL <= '0;
            pri     <= '0;
        end else if (found) begin
            GNT     <= win_oh;
            MUX_SEL <= win_addr;
            pri     <= win + 1'b1;
        end else begin
            GNT     <= '0;
        end
    end

    // Return stage: the mux output is valid in the grant cycle, so capture it
    // and forward the grant as the valid tag. Reset clears GNT, which drops
    // any in-flight return.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RDATA  <= '0;
            RVALID <= '0;
        end else begin
            RVALID <= GNT;
            if (|GNT) begin
                RDATA <= MUX_DATA;
            end
        end
    end

endmodule
